imem_loader: RTL and testbench
==============================

# imem_loader

Hardware program loader that fills the pipelined CPU's instruction memory from a byte stream and holds the CPU in reset until the image is complete. It replaces the bench-side instruction preload for FPGA bring-up. It sits between a byte source (UART receiver or debug bridge) and the fetch-stage instruction memory write port. It releases the CPU, watches `halt`, and re-arms for a new image after the program stops.

## Interface
- `IMEM_DEPTH`, 256: instruction memory depth in 32-bit words (power of two).
- `ADDR_W`, `$clog2(IMEM_DEPTH)`: word-address width.
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-low; clock `clk`.
- `s_valid`  in  1  byte available.
- `s_data`  in  8  stream byte, little-endian within each word.
- `s_last`  in  1  marks the final byte of the image; qualified by `s_valid`.
- `s_ready`  out  1  loader accepts a byte this cycle.
- `imem_we`  out  1  one-cycle word write strobe.
- `imem_addr`  out  ADDR_W  word address.
- `imem_wdata`  out  32  assembled instruction.
- `cpu_hold`  out  1  1 holds the CPU in reset.
- `halt`  in  1  CPU halted.
- `done`  out  1  program ran and halted.
- `overflow`  out  1  sticky; the image exceeded `IMEM_DEPTH` words.
- `words_loaded`  out  ADDR_W+1  words written in the current image.
- `cksum_err`  out  1  checksum failure (see Configuration).

## Operation
- A byte is accepted on any cycle where `s_valid & s_ready` is high.
- States:
  - LOAD: `s_ready`=1. Each accepted byte goes into bits [8*k+7:8*k] of the word buffer, where k = `byte_cnt` (0..3).
    - k==3, or `s_last` accepted → WRITE. On `s_last` with k<3, the unfilled upper bytes are zero.
  - WRITE: `s_ready`=0.
    - `imem_we`=1, `imem_addr`=`word_ptr`, `imem_wdata`=buffer.
    - If `word_ptr`==`IMEM_DEPTH`, no write is issued: `imem_we` stays 0 and `overflow` is set.
    - Otherwise `word_ptr`++ and `words_loaded`++.
    - Then → RUN if the word ended with `s_last`, else → LOAD.
  - RUN: `cpu_hold`=0, `s_ready`=0. `halt`=1 → HALTED.
  - HALTED: `done`=1, `cpu_hold`=0, `s_ready`=1.
    - An accepted byte starts a new image: `cpu_hold`=1, `done`=0, and `word_ptr`, `words_loaded`, `overflow` and `byte_cnt` are cleared.
    - That byte is byte 0 of the new image; → LOAD. If it carries `s_last`, → WRITE.
- Overflow handling: once `word_ptr` hits `IMEM_DEPTH`, bytes are still accepted and discarded, and `s_last` still completes the image. `cpu_hold` is released anyway; `overflow` reports the truncation.
- `halt` is ignored outside RUN.
- `s_last` with `s_valid`=0 has no effect.

## Timing
- Reset state (`rst`=0 at a posedge):
  - state LOAD.
  - `cpu_hold`=1, `s_ready`=1, `done`=0.
  - `imem_we`=0, `imem_addr`=0, `imem_wdata`=0.
  - `overflow`=0, `words_loaded`=0, `cksum_err`=0.
  - `byte_cnt`=0, `word_ptr`=0.
- Reset mid-operation discards any partial word and does not write it. The CPU stays held.
- `imem_we` is high in the cycle after the 4th (or last) byte is accepted. `s_ready` is low in that same cycle, giving a one-cycle bubble per word.
- Full-rate stream: 4 words take 20 cycles.
- `cpu_hold` falls in the cycle after the final WRITE.
- `done` rises in the cycle after `halt` is sampled high in RUN.
- All outputs are registered. `s_ready` is a function of the registered state only.

## Configuration
- `IMEM_LOADER_CKSUM_EN` defined:
  - The `s_last` byte is a checksum trailer and is not written to memory. Its preceding data is flushed as a (zero-padded) partial word if `byte_cnt`≠0.
  - A running 8-bit sum of all accepted bytes, trailer included, must equal 0 mod 256.
  - If it is nonzero: `cksum_err`=1, state → HALTED with `cpu_hold`=1 and `done`=0. The CPU is never released, and a new image may be sent.
  - `cksum_err` clears when a new image starts.
- Not defined: `s_last` is a data byte, and `cksum_err` is tied to 0.

## Structure
- Shared package `imem_loader_pkg`:
  - state enum `loader_state_e` {LOAD, WRITE, RUN, HALTED}.
  - `BYTES_PER_WORD`=4.
- Sub-module `word_assembler`: byte counter, little-endian shift buffer, zero padding, and `word_ready` pulse.
- Top-level FSM: pointer, hold/done logic, checksum.

## Test plan
- 8 bytes `13 05 A0 02 93 05 30 00` (`s_last` on last), full rate → writes `imem[0]`=0x02A00513 and `imem[1]`=0x00300593; `words_loaded`=2; `cpu_hold` falls 1 cycle after the 2nd write.
- 6-byte image ending `s_last` → `imem[1]`=0x0000_YYXX (zero-padded); → RUN.
- `s_valid` toggling every other cycle, plus `rst` asserted after byte 2 → no `imem_we`; after reset a full image loads from address 0.
- `IMEM_DEPTH`=4, 6-word image → `imem[0..3]` written, `overflow`=1, `words_loaded`=4, CPU released.
- RUN, then `halt`=1 → `done`=1 next cycle; a new byte → `cpu_hold`=1, `done`=0, reload starts at address 0.
- With `IMEM_LOADER_CKSUM_EN`: bytes `01 02 03 04` then trailer 0xF6 → `imem[0]`=0x04030201, CPU released. Trailer 0xF5 → `cksum_err`=1 and `cpu_hold` stays 1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    WRITE  = 2'd1,
    RUN    = 2'd2,
    HALTED = 2'd3
  } loader_state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 32;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs accepted stream bytes little-endian into 32-bit words and pulses
// o_word_ready in the cycle after a word closes (4th byte, s_last, or trailer flush).
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_accept,
  input  logic [7:0]        i_data,
  input  logic              i_last,
  input  logic              i_trailer,
  output logic [1:0]        o_byte_cnt,
  output logic [WORD_W-1:0] o_word,
  output logic              o_word_ready
);

  logic [1:0]        r_cnt;
  logic [WORD_W-1:0] r_buf;
  logic [WORD_W-1:0] r_word;
  logic              r_ready;
  logic [WORD_W-1:0] w_merged;
  logic              w_close;

  always_comb begin
    w_merged                        = r_buf;
    w_merged[{r_cnt, 3'b000} +: 8]  = i_data;
    w_close = i_last || (r_cnt == 2'(BYTES_PER_WORD - 1));
  end

  // The buffer is cleared whenever a word leaves, so partial words come out zero-padded.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_buf   <= '0;
      r_word  <= '0;
      r_ready <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      if (i_accept) begin
        if (i_trailer) begin
          r_cnt <= '0;
          r_buf <= '0;
          if (r_cnt != 2'd0) begin
            r_ready <= 1'b1;
            r_word  <= r_buf;
          end
        end else if (w_close) begin
          r_cnt   <= '0;
          r_buf   <= '0;
          r_ready <= 1'b1;
          r_word  <= w_merged;
        end else begin
          r_cnt <= r_cnt + 2'd1;
          r_buf <= w_merged;
        end
      end
    end
  end

  assign o_byte_cnt   = r_cnt;
  assign o_word       = r_word;
  assign o_word_ready = r_ready;

endmodule

// File: rtl/imem_loader.sv
// Loads a byte-stream program image into instruction memory, holds the CPU in reset
// until complete, then re-arms after halt. Define IMEM_LOADER_CKSUM_EN for checksum trailer.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int IMEM_DEPTH = 256,
  parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_hold,
  input  logic              halt,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   words_loaded,
  output logic              cksum_err
);

  localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W + 1)'(IMEM_DEPTH);

  loader_state_e     r_state, w_state_nxt;
  logic [ADDR_W:0]   r_word_ptr, w_ptr_nxt;
  logic [ADDR_W:0]   r_words_loaded, w_loaded_nxt;
  logic              r_overflow, w_ovf_nxt;
  logic              r_done, w_done_nxt;
  logic              r_cpu_hold, w_hold_nxt;
  logic              r_s_ready, w_ready_nxt;
  logic              r_imem_we, w_we_nxt;
  logic [ADDR_W-1:0] r_imem_addr, w_addr_nxt;
  logic              r_last, w_last_nxt;
  logic              r_cksum_err, w_err_nxt;
  logic [7:0]        r_sum, w_sum_nxt;

  logic              w_accept;
  logic              w_new_img;
  logic              w_emit;
  logic              w_trailer;
  logic              w_sum_bad;
  logic [ADDR_W:0]   w_ptr_base;
  logic [7:0]        w_sum_byte;
  logic [1:0]        w_byte_cnt;
  logic              w_word_ready;
  logic [WORD_W-1:0] w_word;

  assign w_accept   = s_valid & r_s_ready;
  assign w_new_img  = (r_state == HALTED) & w_accept;
  assign w_ptr_base = w_new_img ? '0 : r_word_ptr;
  assign w_sum_byte = (w_new_img ? 8'd0 : r_sum) + s_data;

`ifdef IMEM_LOADER_CKSUM_EN
  // The s_last byte is a checksum trailer: it only flushes a pending partial word.
  assign w_trailer = w_accept & s_last;
  assign w_emit    = w_accept & (s_last ? (w_byte_cnt != 2'd0)
                                        : (w_byte_cnt == 2'(BYTES_PER_WORD - 1)));
  assign w_sum_bad = (r_sum != 8'd0);
`else
  assign w_trailer = 1'b0;
  assign w_emit    = w_accept & (s_last | (w_byte_cnt == 2'(BYTES_PER_WORD - 1)));
  assign w_sum_bad = 1'b0;
`endif

  word_assembler u_asm (
    .clk          (clk),
    .rst          (rst),
    .i_accept     (w_accept),
    .i_data       (s_data),
    .i_last       (s_last),
    .i_trailer    (w_trailer),
    .o_byte_cnt   (w_byte_cnt),
    .o_word       (w_word),
    .o_word_ready (w_word_ready)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_word_ptr;
    w_loaded_nxt = r_words_loaded;
    w_ovf_nxt    = r_overflow;
    w_done_nxt   = r_done;
    w_hold_nxt   = r_cpu_hold;
    w_we_nxt     = 1'b0;
    w_addr_nxt   = r_imem_addr;
    w_last_nxt   = r_last;
    w_err_nxt    = r_cksum_err;
    w_sum_nxt    = r_sum;
    unique case (r_state)
      LOAD, HALTED: begin
        if (w_accept) begin
          w_sum_nxt = w_sum_byte;
          if (w_new_img) begin
            w_state_nxt  = LOAD;
            w_hold_nxt   = 1'b1;
            w_done_nxt   = 1'b0;
            w_ptr_nxt    = '0;
            w_loaded_nxt = '0;
            w_ovf_nxt    = 1'b0;
            w_err_nxt    = 1'b0;
          end
          if (w_emit) begin
            w_state_nxt = WRITE;
            w_last_nxt  = s_last;
            w_addr_nxt  = w_ptr_base[ADDR_W-1:0];
            w_we_nxt    = (w_ptr_base != DEPTH_P);
            if (w_ptr_base == DEPTH_P) w_ovf_nxt = 1'b1;
          end else if (w_trailer) begin
            // Trailer on a word boundary: nothing to flush, finish the image now.
            if (w_sum_byte != 8'd0) begin
              w_state_nxt = HALTED;
              w_err_nxt   = 1'b1;
            end else begin
              w_state_nxt = RUN;
              w_hold_nxt  = 1'b0;
            end
          end
        end
      end
      WRITE: begin
        if (w_word_ready && (r_word_ptr != DEPTH_P)) begin
          w_ptr_nxt    = r_word_ptr + 1'b1;
          w_loaded_nxt = r_words_loaded + 1'b1;
        end
        if (!r_last) begin
          w_state_nxt = LOAD;
        end else if (w_sum_bad) begin
          w_state_nxt = HALTED;
          w_err_nxt   = 1'b1;
        end else begin
          w_state_nxt = RUN;
          w_hold_nxt  = 1'b0;
        end
      end
      RUN: begin
        if (halt) begin
          w_state_nxt = HALTED;
          w_done_nxt  = 1'b1;
        end
      end
      default: ;
    endcase
    w_ready_nxt = (w_state_nxt == LOAD) || (w_state_nxt == HALTED);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= LOAD;
      r_word_ptr     <= '0;
      r_words_loaded <= '0;
      r_overflow     <= 1'b0;
      r_done         <= 1'b0;
      r_cpu_hold     <= 1'b1;
      r_s_ready      <= 1'b1;
      r_imem_we      <= 1'b0;
      r_imem_addr    <= '0;
      r_last         <= 1'b0;
      r_cksum_err    <= 1'b0;
      r_sum          <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_word_ptr     <= w_ptr_nxt;
      r_words_loaded <= w_loaded_nxt;
      r_overflow     <= w_ovf_nxt;
      r_done         <= w_done_nxt;
      r_cpu_hold     <= w_hold_nxt;
      r_s_ready      <= w_ready_nxt;
      r_imem_we      <= w_we_nxt;
      r_imem_addr    <= w_addr_nxt;
      r_last         <= w_last_nxt;
      r_cksum_err    <= w_err_nxt;
      r_sum          <= w_sum_nxt;
    end
  end

  assign s_ready      = r_s_ready;
  assign imem_we      = r_imem_we;
  assign imem_addr    = r_imem_addr;
  assign imem_wdata   = w_word;
  assign cpu_hold     = r_cpu_hold;
  assign done         = r_done;
  assign overflow     = r_overflow;
  assign words_loaded = r_words_loaded;
  assign cksum_err    = r_cksum_err;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of images plus hand sequences for reset,
// re-arm and overflow (second instance with IMEM_DEPTH=4).
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        halt = 1'b0;
  logic [7:0]  s_data = 8'h00;

  logic        s_ready, imem_we, cpu_hold, done, overflow, cksum_err;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [8:0]  words_loaded;

  logic        s_ready4, we4, hold4, done4, ovf4, ck4;
  logic [1:0]  addr4;
  logic [31:0] wdata4;
  logic [2:0]  wl4;

  always #5 clk = ~clk;

  imem_loader dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .halt(halt), .done(done), .overflow(overflow),
    .words_loaded(words_loaded), .cksum_err(cksum_err)
  );

  imem_loader #(.IMEM_DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready4), .imem_we(we4), .imem_addr(addr4), .imem_wdata(wdata4),
    .cpu_hold(hold4), .halt(halt), .done(done4), .overflow(ovf4),
    .words_loaded(wl4), .cksum_err(ck4)
  );

  // Write log and timing monitor, sampled on the falling edge.
  int          cyc = 0, nwr = 0, nwr4 = 0, last_we_cyc = 0, hold_fall_cyc = 0;
  logic        prev_hold = 1'b1;
  logic [7:0]  log_addr [64];
  logic [31:0] log_data [64];
  logic [1:0]  addr4_last = 2'd0;
  logic [31:0] data4_last = 32'd0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (imem_we) begin
      if (nwr < 64) begin
        log_addr[nwr] = imem_addr;
        log_data[nwr] = imem_wdata;
      end
      nwr = nwr + 1;
      last_we_cyc = cyc;
    end
    if (prev_hold && !cpu_hold) hold_fall_cyc = cyc;
    prev_hold = cpu_hold;
    if (we4) begin
      nwr4 = nwr4 + 1;
      addr4_last = addr4;
      data4_last = wdata4;
    end
  end

  typedef struct packed {
    logic [3:0]  n;
    logic [63:0] b;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [2:0]  nw;
  } vec_t;

  vec_t vt [4];
  int   errors = 0, checks = 0;
  int   c0, base, base4;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int t;
    t = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!s_ready && t < 40) begin
      tick();
      t = t + 1;
    end
    if (!s_ready) chk("sready_timeout", 64'(s_ready), 64'd1);
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_release(input logic use4);
    int t;
    t = 0;
    while ((use4 ? hold4 : cpu_hold) && t < 40) begin
      tick();
      t = t + 1;
    end
    chk("release_timeout", 64'(use4 ? hold4 : cpu_hold), 64'd0);
    tick();
  endtask

  task automatic halt_pulse();
    halt = 1'b1;
    tick();
    halt = 1'b0;
  endtask

  initial begin
    vt[0] = '{4'd8, 64'h0030_0593_02A0_0513, 32'h02A0_0513, 32'h0030_0593, 3'd2};
    vt[1] = '{4'd6, 64'h0000_6655_4433_2211, 32'h4433_2211, 32'h0000_6655, 3'd2};
    vt[2] = '{4'd1, 64'h0000_0000_0000_00AB, 32'h0000_00AB, 32'h0000_0000, 3'd1};
    vt[3] = '{4'd7, 64'h0007_0605_0403_0201, 32'h0403_0201, 32'h0007_0605, 3'd2};

    rst = 1'b0;
    repeat (3) tick();
    chk("rst_hold",   64'(cpu_hold),     64'd1);
    chk("rst_sready", 64'(s_ready),      64'd1);
    chk("rst_done",   64'(done),         64'd0);
    chk("rst_we",     64'(imem_we),      64'd0);
    chk("rst_addr",   64'(imem_addr),    64'd0);
    chk("rst_wdata",  64'(imem_wdata),   64'd0);
    chk("rst_ovf",    64'(overflow),     64'd0);
    chk("rst_wl",     64'(words_loaded), 64'd0);
    chk("rst_ckerr",  64'(cksum_err),    64'd0);
    rst = 1'b1;
    tick();

`ifdef IMEM_LOADER_CKSUM_EN
    base = nwr;
    send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0); send_byte(8'h04, 1'b0);
    send_byte(8'hF6, 1'b1);
    wait_release(1'b0);
    chk("ck_nwr",   64'(nwr - base),      64'd1);
    chk("ck_data",  64'(log_data[base]),  64'h0403_0201);
    chk("ck_err0",  64'(cksum_err),       64'd0);
    chk("ck_wl",    64'(words_loaded),    64'd1);
    halt_pulse();
    chk("ck_done",  64'(done),            64'd1);
    send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0); send_byte(8'h04, 1'b0);
    send_byte(8'hF5, 1'b1);
    repeat (3) tick();
    chk("ck_err1",  64'(cksum_err),       64'd1);
    chk("ck_hold1", 64'(cpu_hold),        64'd1);
    chk("ck_done1", 64'(done),            64'd0);
    chk("ck_rdy1",  64'(s_ready),         64'd1);
    base = nwr;
    send_byte(8'h0A, 1'b0); send_byte(8'h0B, 1'b0);
    send_byte(8'hEB, 1'b1);
    wait_release(1'b0);
    chk("ck_flush", 64'(log_data[base]),  64'h0000_0B0A);
    chk("ck_faddr", 64'(log_addr[base]),  64'd0);
    chk("ck_clr",   64'(cksum_err),       64'd0);
`else
    // Half-rate bytes with halt held high, then reset mid-word.
    halt = 1'b1;
    send_byte(8'h55, 1'b0);
    tick();
    send_byte(8'h66, 1'b0);
    tick();
    chk("halt_ign_done", 64'(done),     64'd0);
    chk("halt_ign_hold", 64'(cpu_hold), 64'd1);
    rst = 1'b0;
    halt = 1'b0;
    tick();
    rst = 1'b1;
    repeat (6) tick();
    chk("midrst_nowr", 64'(nwr),          64'd0);
    chk("midrst_hold", 64'(cpu_hold),     64'd1);
    chk("midrst_rdy",  64'(s_ready),      64'd1);
    chk("midrst_wl",   64'(words_loaded), 64'd0);

    for (int v = 0; v < 4; v++) begin
      base = nwr;
      c0 = cyc;
      for (int i = 0; i < int'(vt[v].n); i++)
        send_byte(vt[v].b[8*i +: 8], (i == int'(vt[v].n) - 1));
      wait_release(1'b0);
      chk($sformatf("v%0d_wl", v),   64'(words_loaded),        64'(vt[v].nw));
      chk($sformatf("v%0d_nwr", v),  64'(nwr - base),          64'(vt[v].nw));
      chk($sformatf("v%0d_a0", v),   64'(log_addr[base]),      64'd0);
      chk($sformatf("v%0d_d0", v),   64'(log_data[base]),      64'(vt[v].w0));
      if (vt[v].nw > 3'd1) begin
        chk($sformatf("v%0d_a1", v), 64'(log_addr[base + 1]),  64'd1);
        chk($sformatf("v%0d_d1", v), 64'(log_data[base + 1]),  64'(vt[v].w1));
      end
      chk($sformatf("v%0d_lat", v),  64'(last_we_cyc - c0),    64'(int'(vt[v].n) + int'(vt[v].nw)));
      chk($sformatf("v%0d_hfall", v), 64'(hold_fall_cyc - last_we_cyc), 64'd1);
      chk($sformatf("v%0d_run_rdy", v), 64'(s_ready),          64'd0);
      chk($sformatf("v%0d_run_done", v), 64'(done),            64'd0);
      halt_pulse();
      chk($sformatf("v%0d_done", v), 64'(done),                64'd1);
      chk($sformatf("v%0d_hrdy", v), 64'(s_ready),             64'd1);
      chk($sformatf("v%0d_ckerr", v), 64'(cksum_err),          64'd0);
    end

    // Re-arm from HALTED: the first byte re-holds the CPU and clears the counts.
    send_byte(8'hC3, 1'b0);
    chk("rearm_hold", 64'(cpu_hold),     64'd1);
    chk("rearm_done", 64'(done),         64'd0);
    chk("rearm_wl",   64'(words_loaded), 64'd0);
    base = nwr;
    send_byte(8'h3C, 1'b1);
    wait_release(1'b0);
    chk("rearm_addr", 64'(log_addr[base]), 64'd0);
    chk("rearm_data", 64'(log_data[base]), 64'h0000_3CC3);
    halt_pulse();

    // Six-word image into the depth-4 instance.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    base4 = nwr4;
    for (int i = 0; i < 24; i++) send_byte(8'(i), (i == 23));
    wait_release(1'b1);
    chk("ovf_nwr4",  64'(nwr4 - base4),  64'd4);
    chk("ovf_addr4", 64'(addr4_last),    64'd3);
    chk("ovf_data4", 64'(data4_last),    64'h0F0E_0D0C);
    chk("ovf_wl4",   64'(wl4),           64'd4);
    chk("ovf_flag4", 64'(ovf4),          64'd1);
    chk("ovf_hold4", 64'(hold4),         64'd0);
    chk("ovf_ck4",   64'(ck4),           64'd0);
    chk("ovf_big",   64'(overflow),      64'd0);
    chk("ovf_bigwl", 64'(words_loaded),  64'd6);
    halt_pulse();
    chk("ovf_done4", 64'(done4),         64'd1);
    chk("ovf_rdy4",  64'(s_ready4),      64'd1);
    send_byte(8'h77, 1'b0);
    chk("ovf_clr4",  64'(ovf4),          64'd0);
    chk("ovf_rehold4", 64'(hold4),       64'd1);
    chk("ovf_rewl4", 64'(wl4),           64'd0);
    send_byte(8'h88, 1'b1);
    wait_release(1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

endmodule
